// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IF/DM memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    LAST_NONE = 2'd0,
    LAST_IF   = 2'd1,
    LAST_DM   = 2'd2
  } grant_phase_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating counter of consecutive cycles the IF port waited on a grant.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  output logic [STARVE_CNT_W-1:0] cnt,
  output logic                    at_limit
);

  logic [STARVE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != STARVE_CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + STARVE_CNT_W'(1);
    end
  end

  assign cnt      = r_cnt;
  assign at_limit = (r_cnt == STARVE_CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory ports.
// DM wins by default; IF wins once it has been denied STARVE_LIMIT cycles in a row.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BYTE_SIZE    = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [ADDR_WIDTH-1:0]    if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [8*BYTE_SIZE-1:0]   if_rdata,
  input  logic                     dm_req,
  input  logic                     dm_we,
  input  logic [ADDR_WIDTH-1:0]    dm_addr,
  input  logic [8*BYTE_SIZE-1:0]   dm_wdata,
  output logic                     dm_gnt,
  output logic                     dm_rvalid,
  output logic [8*BYTE_SIZE-1:0]   dm_rdata,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [8*BYTE_SIZE-1:0]   mem_wd,
  input  logic [8*BYTE_SIZE-1:0]   mem_rd
);

  localparam int unsigned DATA_W = 8 * BYTE_SIZE;

  logic [STARVE_CNT_W-1:0] w_starve_cnt;
  logic                    w_at_limit;
  logic                    w_if_gnt;
  logic                    w_dm_gnt;
  logic                    w_dm_rd;

  grant_phase_e            r_phase;
  logic [DATA_W-1:0]       r_if_rdata;
  logic [DATA_W-1:0]       r_dm_rdata;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (if_req & ~w_if_gnt),
    .clr      (~if_req | w_if_gnt),
    .cnt      (w_starve_cnt),
    .at_limit (w_at_limit)
  );

  // Grants are forced low while reset is held so nothing reaches the memory.
  assign w_if_gnt = ~reset & if_req & (~dm_req | w_at_limit);
  assign w_dm_gnt = ~reset & dm_req &
                    (~if_req | (w_starve_cnt < STARVE_CNT_W'(STARVE_LIMIT)));
  assign w_dm_rd  = w_dm_gnt & ~dm_we;

  assign if_gnt   = w_if_gnt;
  assign dm_gnt   = w_dm_gnt;
  assign mem_we   = w_dm_gnt & dm_we;
  assign mem_wd   = dm_wdata;
  assign mem_addr = w_if_gnt ? if_addr : (w_dm_gnt ? dm_addr : '0);

  // Phase remembers which port owns the read data captured at the last edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= LAST_NONE;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_if_gnt) begin
        r_phase    <= LAST_IF;
        r_if_rdata <= mem_rd;
      end else if (w_dm_rd) begin
        r_phase    <= LAST_DM;
        r_dm_rdata <= mem_rd;
      end else begin
        r_phase    <= LAST_NONE;
      end
    end
  end

  assign if_rvalid = (r_phase == LAST_IF);
  assign dm_rvalid = (r_phase == LAST_DM);
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed memory model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic          mem_init;
  logic [7:0]    mem [0:255];
  logic [7:0]    a0, a1, a2, a3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .BYTE_SIZE    (4),
    .ADDR_WIDTH   (AW),
    .STARVE_LIMIT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd)
  );

  // Little-endian memory: combinational read, write at the rising edge.
  assign a0 = mem_addr[7:0];
  assign a1 = mem_addr[7:0] + 8'd1;
  assign a2 = mem_addr[7:0] + 8'd2;
  assign a3 = mem_addr[7:0] + 8'd3;
  assign mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (mem_we) begin
      mem[a0] <= mem_wd[7:0];
      mem[a1] <= mem_wd[15:8];
      mem[a2] <= mem_wd[23:16];
      mem[a3] <= mem_wd[31:24];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we} !== 5'b0) begin
      n_err++; $display("FAIL por_flags: got %b want 00000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we});
    end
    tick();
    reset = 1'b0;
    mem_init = 1'b0;
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    n_vec++;
    if (if_gnt !== 1'b1) begin n_err++; $display("FAIL rst_first_gnt: got %b want 1", if_gnt); end
    tick();
    n_vec++;
    if (if_rvalid !== 1'b1) begin n_err++; $display("FAIL rst_pre_rvalid: got %b want 1", if_rvalid); end
    // Assert reset mid-cycle with a response pending and IF still requesting.
    reset = 1'b1; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20;
    #1;
    n_vec++;
    if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we} !== 5'b0) begin
      n_err++; $display("FAIL rst_flags: got %b want 00000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_we});
    end
    n_vec++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      n_err++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, dm_rdata});
    end
    n_vec++;
    if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({if_gnt, if_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL rst_release: got gnt,rvalid=%b want 10", {if_gnt, if_rvalid});
    end
    tick();
    idle();
    n_vec++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h07060504}) begin
      n_err++; $display("FAIL rst_after_read: got %b %h want 1 07060504", if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    n_vec++;
    if ({if_gnt, dm_gnt, mem_we, mem_addr} !== {3'b100, 32'h4}) begin
      n_err++; $display("FAIL if_read_gnt: got %b %h want 100 4", {if_gnt, dm_gnt, mem_we}, mem_addr);
    end
    tick();
    idle();
    n_vec++;
    if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'h07060504}) begin
      n_err++; $display("FAIL if_read_resp: got %b %h want 10 07060504", {if_rvalid, dm_rvalid}, if_rdata);
    end
    tick();
    n_vec++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h07060504}) begin
      n_err++; $display("FAIL if_read_hold: got %b %h want 0 07060504", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_dm_write_read();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8; dm_wdata = 32'hDEADBEEF;
    #1;
    n_vec++;
    if ({dm_gnt, if_gnt, mem_we, mem_addr, mem_wd} !== {3'b101, 32'h8, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL dm_write: got %b %h %h want 101 8 deadbeef", {dm_gnt, if_gnt, mem_we}, mem_addr, mem_wd);
    end
    tick();
    dm_we = 1'b0; dm_wdata = 32'h0;
    #1;
    n_vec++;
    if ({dm_rvalid, dm_gnt, mem_we} !== 3'b010) begin
      n_err++; $display("FAIL dm_read_issue: got %b want 010", {dm_rvalid, dm_gnt, mem_we});
    end
    tick();
    idle();
    n_vec++;
    if ({dm_rvalid, if_rvalid, dm_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL dm_read_resp: got %b %h want 10 deadbeef", {dm_rvalid, if_rvalid}, dm_rdata);
    end
    tick();
  endtask

  task automatic test_contention();
    logic exp_if;
    logic prev_if;
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    prev_if = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_if = ((i % 4) == 3);
      #1;
      n_vec++;
      if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
        n_err++; $display("FAIL contend_gnt[%0d]: got if,dm=%b want %b", i, {if_gnt, dm_gnt}, {exp_if, ~exp_if});
      end
      if (i > 0) begin
        n_vec++;
        if ({if_rvalid, dm_rvalid} !== {prev_if, ~prev_if}) begin
          n_err++; $display("FAIL contend_rvalid[%0d]: got if,dm=%b want %b", i, {if_rvalid, dm_rvalid}, {prev_if, ~prev_if});
        end
        n_vec++;
        if (prev_if ? (if_rdata !== 32'h13121110) : (dm_rdata !== 32'h23222120)) begin
          n_err++; $display("FAIL contend_rdata[%0d]: got if=%h dm=%h want 13121110/23222120", i, if_rdata, dm_rdata);
        end
      end
      prev_if = exp_if;
      tick();
    end
    idle();
    n_vec++;
    if ({if_rvalid, dm_rvalid, if_rdata} !== {2'b10, 32'h13121110}) begin
      n_err++; $display("FAIL contend_last: got %b %h want 10 13121110", {if_rvalid, dm_rvalid}, if_rdata);
    end
    tick();
  endtask

  task automatic test_alternating();
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    #1;
    n_vec++;
    if ({if_rvalid, dm_rvalid, dm_gnt, if_rdata} !== {3'b101, 32'h33323130}) begin
      n_err++; $display("FAIL alt_if_resp: got %b %h want 101 33323130", {if_rvalid, dm_rvalid, dm_gnt}, if_rdata);
    end
    tick();
    idle();
    n_vec++;
    if ({if_rvalid, dm_rvalid, dm_rdata, if_rdata} !== {2'b01, 32'h43424140, 32'h33323130}) begin
      n_err++; $display("FAIL alt_dm_resp: got %b %h %h want 01 43424140 33323130", {if_rvalid, dm_rvalid}, dm_rdata, if_rdata);
    end
    tick();
  endtask

  task automatic test_withdrawal();
    logic exp_if;
    if_req = 1'b1; if_addr = 32'h50;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if ({if_gnt, dm_gnt} !== 2'b01) begin
        n_err++; $display("FAIL wd_starve[%0d]: got if,dm=%b want 01", i, {if_gnt, dm_gnt});
      end
      tick();
    end
    idle();
    #1;
    n_vec++;
    if ({if_gnt, dm_gnt, mem_addr} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL wd_drop: got %b %h want 00 0", {if_gnt, dm_gnt}, mem_addr);
    end
    tick();
    n_vec++;
    if ({if_rvalid, dm_rvalid} !== 2'b00) begin
      n_err++; $display("FAIL wd_no_resp: got %b want 00", {if_rvalid, dm_rvalid});
    end
    // A cleared counter means DM again wins three times before IF.
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_if = (i == 3);
      #1;
      n_vec++;
      if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin
        n_err++; $display("FAIL wd_regrant[%0d]: got if,dm=%b want %b", i, {if_gnt, dm_gnt}, {exp_if, ~exp_if});
      end
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    tick();
    test_reset();
    test_if_read();
    test_dm_write_read();
    test_contention();
    test_alternating();
    test_withdrawal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
